// File: rtl/cpu_step_pkg.sv
// Shared encodings for the front-panel CPU clock-enable controller:
// controller states and the front-panel mode switch values.
package cpu_step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2,
    ST_BREAK = 2'd3
  } state_e;

  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector for a level that is already synchronous
// to clk; rise is high for the single cycle in which the level goes 0 -> 1.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in_lvl,
  output logic rise
);

  logic prev_d;
  logic prev_q;

  always_comb prev_d = in_lvl;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign rise = in_lvl & ~prev_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Debug front-panel clock-enable controller: HALT / RUN / STEP / BURST pacing of
// PHI2_EN plus opcode-fetch breakpoints with a skip-once resume.
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int NUM_BP  = 2,
  parameter int BURST_W = 8,
  parameter int DIV_W   = 4
) (
  input  logic                     CLK,
  input  logic                     RESET_n,
  input  logic [1:0]               mode,
  input  logic                     step_req,
  input  logic                     resume,
  input  logic [BURST_W-1:0]       burst_len,
  input  logic [DIV_W-1:0]         div,
  input  logic [ADDR_W-1:0]        A,
  input  logic                     SYNC,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  output logic                     PHI2_EN,
  output logic                     halted,
  output logic                     at_break,
  output logic [NUM_BP-1:0]        bp_hit
);

  // One extra bit so a zero burst length can hold the full 2^BURST_W count.
  localparam logic [BURST_W:0] REM_FULL = {1'b1, {BURST_W{1'b0}}};
  localparam logic [BURST_W:0] REM_ONE  = {{BURST_W{1'b0}}, 1'b1};

  logic step_rise;
  logic resume_rise;

  rise_detect u_step_rise (
    .clk    (CLK),
    .rst_n  (RESET_n),
    .in_lvl (step_req),
    .rise   (step_rise)
  );

  rise_detect u_resume_rise (
    .clk    (CLK),
    .rst_n  (RESET_n),
    .in_lvl (resume),
    .rise   (resume_rise)
  );

  logic [NUM_BP-1:0] bp_match;

  for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
    assign bp_match[i] = bp_en[i] & SYNC & (A == bp_addr[i*ADDR_W +: ADDR_W]);
  end

  state_e             state_q,    state_d;
  logic [DIV_W-1:0]   div_cnt_q,  div_cnt_d;
  logic [BURST_W:0]   rem_q,      rem_d;
  logic               skip_q,     skip_d;
  logic [NUM_BP-1:0]  bp_hit_q,   bp_hit_d;
  logic               phi2_en_q,  phi2_en_d;
  logic               halted_q,   halted_d;
  logic               at_break_q, at_break_d;

  logic want_en;
  logic terminal;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = '0;
    rem_d     = rem_q;
    skip_d    = skip_q;
    bp_hit_d  = bp_hit_q;
    phi2_en_d = 1'b0;
    want_en   = 1'b0;
    terminal  = (div_cnt_q == div);

    // Divider only counts while pacing; any state change leaves it cleared.
    unique case (state_q)
      ST_IDLE: begin
        if (mode == MODE_RUN) begin
          state_d = ST_RUN;
        end else if (step_rise && mode == MODE_STEP) begin
          want_en = 1'b1;
        end else if (step_rise && mode == MODE_BURST) begin
          rem_d   = (burst_len == '0) ? REM_FULL : {1'b0, burst_len};
          state_d = ST_BURST;
        end
      end
      ST_RUN: begin
        if (mode != MODE_RUN) state_d   = ST_IDLE;
        else if (terminal)    want_en   = 1'b1;
        else                  div_cnt_d = div_cnt_q + 1'b1;
      end
      ST_BURST: begin
        if (mode != MODE_BURST) state_d   = (mode == MODE_RUN) ? ST_RUN : ST_IDLE;
        else if (terminal)      want_en   = 1'b1;
        else                    div_cnt_d = div_cnt_q + 1'b1;
      end
      ST_BREAK: begin
        if (resume_rise) begin
          bp_hit_d = '0;
          skip_d   = 1'b1;
          state_d  = (mode == MODE_RUN) ? ST_RUN : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Skip lets exactly one enable through at the address we broke on.
    if (want_en) begin
      if ((|bp_match) && !skip_q) begin
        bp_hit_d = bp_match;
        state_d  = ST_BREAK;
      end else begin
        phi2_en_d = 1'b1;
        skip_d    = 1'b0;
        if (state_q == ST_BURST) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == REM_ONE) state_d = ST_IDLE;
        end
      end
    end

    halted_d   = (state_d == ST_IDLE) || (state_d == ST_BREAK);
    at_break_d = (state_d == ST_BREAK);
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      rem_q      <= '0;
      skip_q     <= 1'b0;
      bp_hit_q   <= '0;
      phi2_en_q  <= 1'b0;
      halted_q   <= 1'b1;
      at_break_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      rem_q      <= rem_d;
      skip_q     <= skip_d;
      bp_hit_q   <= bp_hit_d;
      phi2_en_q  <= phi2_en_d;
      halted_q   <= halted_d;
      at_break_q <= at_break_d;
    end
  end

  assign PHI2_EN  = phi2_en_q;
  assign halted   = halted_q;
  assign at_break = at_break_q;
  assign bp_hit   = bp_hit_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: directed front-panel scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the controller rules.
module tb_cpu_step_ctrl;
  import cpu_step_pkg::*;

  localparam int ADDR_W  = 16;
  localparam int NUM_BP  = 2;
  localparam int BURST_W = 8;
  localparam int DIV_W   = 4;

  logic                     CLK = 1'b0;
  logic                     RESET_n = 1'b0;
  logic [1:0]               mode = MODE_HALT;
  logic                     step_req = 1'b0;
  logic                     resume = 1'b0;
  logic [BURST_W-1:0]       burst_len = '0;
  logic [DIV_W-1:0]         div = '0;
  logic [ADDR_W-1:0]        A = '0;
  logic                     SYNC = 1'b0;
  logic [NUM_BP*ADDR_W-1:0] bp_addr = '0;
  logic [NUM_BP-1:0]        bp_en = '0;
  logic                     PHI2_EN;
  logic                     halted;
  logic                     at_break;
  logic [NUM_BP-1:0]        bp_hit;

  int n_cmp = 0;
  int n_err = 0;

  cpu_step_ctrl #(
    .ADDR_W (ADDR_W),
    .NUM_BP (NUM_BP),
    .BURST_W(BURST_W),
    .DIV_W  (DIV_W)
  ) dut (
    .CLK      (CLK),
    .RESET_n  (RESET_n),
    .mode     (mode),
    .step_req (step_req),
    .resume   (resume),
    .burst_len(burst_len),
    .div      (div),
    .A        (A),
    .SYNC     (SYNC),
    .bp_addr  (bp_addr),
    .bp_en    (bp_en),
    .PHI2_EN  (PHI2_EN),
    .halted   (halted),
    .at_break (at_break),
    .bp_hit   (bp_hit)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: predicts the registered outputs visible after each edge.
  localparam int M_IDLE = 0, M_RUN = 1, M_BURST = 2, M_BREAK = 3;
  int                m_state, m_cnt, m_rem, m_nxt;
  bit                m_skip, m_ps, m_pr, m_en, m_halted, m_brk, m_want, m_se, m_re;
  logic [NUM_BP-1:0] m_hit, m_match;

  always @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      m_state = M_IDLE; m_cnt = 0; m_rem = 0; m_skip = 0; m_ps = 0; m_pr = 0;
      m_en = 0; m_halted = 1; m_brk = 0; m_hit = '0;
    end else begin
      m_se = step_req && !m_ps;
      m_re = resume && !m_pr;
      m_ps = step_req;
      m_pr = resume;
      for (int i = 0; i < NUM_BP; i++)
        m_match[i] = bp_en[i] && SYNC && (A == bp_addr[i*ADDR_W +: ADDR_W]);
      m_want = 0;
      m_en   = 0;
      m_nxt  = m_state;
      case (m_state)
        M_IDLE: begin
          if (mode == MODE_RUN) m_nxt = M_RUN;
          else if (m_se && mode == MODE_STEP) m_want = 1;
          else if (m_se && mode == MODE_BURST) begin
            m_rem = (burst_len == 0) ? (1 << BURST_W) : int'(burst_len);
            m_nxt = M_BURST;
          end
        end
        M_RUN, M_BURST: begin
          if (mode != ((m_state == M_RUN) ? MODE_RUN : MODE_BURST))
            m_nxt = (mode == MODE_RUN) ? M_RUN : M_IDLE;
          else if (m_cnt == int'(div)) begin
            m_want = 1;
            m_cnt  = 0;
          end else m_cnt = (m_cnt + 1) % (1 << DIV_W);
        end
        default: begin
          if (m_re) begin
            m_hit  = '0;
            m_skip = 1;
            m_nxt  = (mode == MODE_RUN) ? M_RUN : M_IDLE;
          end
        end
      endcase
      if (m_want) begin
        if (m_match != 0 && !m_skip) begin
          m_hit = m_match;
          m_nxt = M_BREAK;
        end else begin
          m_en   = 1;
          m_skip = 0;
          if (m_state == M_BURST) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) m_nxt = M_IDLE;
          end
        end
      end
      if (m_nxt != m_state && (m_nxt == M_RUN || m_nxt == M_BURST)) m_cnt = 0;
      m_state  = m_nxt;
      m_halted = (m_state == M_IDLE) || (m_state == M_BREAK);
      m_brk    = (m_state == M_BREAK);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RESET_n = 1'b0; mode = MODE_HALT; step_req = 0; resume = 0; burst_len = '0;
    div = '0; A = '0; SYNC = 0; bp_addr = '0; bp_en = '0;
    repeat (3) tick();
    RESET_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    int pulses = 0, not_halted = 0;
    apply_reset();
    n_cmp++;
    if ({PHI2_EN, halted, at_break, bp_hit} !== 5'b01000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, expected 01000", {PHI2_EN, halted, at_break, bp_hit});
    end
    for (int i = 0; i < 100; i++) begin
      step_req = (i % 10) < 3;
      tick();
      if (PHI2_EN) pulses++;
      if (!halted) not_halted++;
    end
    step_req = 0;
    n_cmp++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL halt_no_pulses: got %0d pulses, expected 0", pulses);
    end
    n_cmp++;
    if (not_halted !== 0) begin
      n_err++;
      $display("FAIL halt_halted: got %0d cycles not halted, expected 0", not_halted);
    end
  endtask

  task automatic test_step();
    mode = MODE_STEP;
    repeat (2) tick();
    for (int k = 0; k < 3; k++) begin
      int pcount = 0, first = -1;
      step_req = 1;
      for (int off = 1; off <= 20; off++) begin
        tick();
        if (PHI2_EN) begin
          pcount++;
          if (first < 0) first = off;
        end
        if (off == 5) step_req = 0;
      end
      n_cmp++;
      if (pcount !== 1) begin
        n_err++;
        $display("FAIL step_count[%0d]: got %0d pulses, expected 1", k, pcount);
      end
      n_cmp++;
      if (first !== 1) begin
        n_err++;
        $display("FAIL step_latency[%0d]: got offset %0d, expected 1", k, first);
      end
    end
    mode = MODE_HALT;
    tick();
  endtask

  task automatic test_burst();
    int offs[$];
    bit h15 = 0, h16 = 0;
    mode = MODE_BURST; div = 4'd2; burst_len = 8'd5;
    repeat (2) tick();
    step_req = 1;
    for (int off = 1; off <= 30; off++) begin
      tick();
      if (off == 2) step_req = 0;
      if (PHI2_EN) offs.push_back(off);
      if (off == 15) h15 = halted;
      if (off == 16) h16 = halted;
    end
    n_cmp++;
    if (offs.size() !== 5) begin
      n_err++;
      $display("FAIL burst5_count: got %0d pulses, expected 5", offs.size());
    end
    for (int i = 0; i < offs.size() && i < 5; i++) begin
      n_cmp++;
      if (offs[i] !== 4 + 3 * i) begin
        n_err++;
        $display("FAIL burst5_pulse[%0d]: got offset %0d, expected %0d", i, offs[i], 4 + 3 * i);
      end
    end
    n_cmp++;
    if ({h15, h16} !== 2'b01) begin
      n_err++;
      $display("FAIL burst5_halted_edge: got %b, expected 01", {h15, h16});
    end
  endtask

  task automatic test_burst_zero();
    int pcount = 0, first = -1, last = -1;
    burst_len = '0; div = '0;
    tick();
    step_req = 1;
    for (int off = 1; off <= 300; off++) begin
      tick();
      if (off == 2) step_req = 0;
      if (PHI2_EN) begin
        pcount++;
        if (first < 0) first = off;
        last = off;
      end
    end
    n_cmp++;
    if (pcount !== 256) begin
      n_err++;
      $display("FAIL burst0_count: got %0d pulses, expected 256", pcount);
    end
    n_cmp++;
    if (first !== 2 || last !== 257) begin
      n_err++;
      $display("FAIL burst0_span: got %0d..%0d, expected 2..257", first, last);
    end
    n_cmp++;
    if (halted !== 1'b1) begin
      n_err++;
      $display("FAIL burst0_halted: got %b, expected 1", halted);
    end
    mode = MODE_HALT;
    tick();
  endtask

  task automatic test_run_div();
    int pcount = 0, first = -1;
    div = '0;
    tick();
    mode = MODE_RUN;
    for (int off = 1; off <= 13; off++) begin
      tick();
      if (PHI2_EN && first < 0) first = off;
      if (PHI2_EN && off >= 3 && off <= 12) pcount++;
    end
    n_cmp++;
    if (first !== 2 || pcount !== 10) begin
      n_err++;
      $display("FAIL run_div0: got first %0d count %0d, expected first 2 count 10", first, pcount);
    end
    div = 4'd3;
    pcount = 0; first = -1;
    for (int off = 1; off <= 16; off++) begin
      tick();
      if (PHI2_EN) begin
        pcount++;
        if (first < 0) first = off;
      end
    end
    n_cmp++;
    if (first !== 4 || pcount !== 4) begin
      n_err++;
      $display("FAIL run_div3: got first %0d count %0d, expected first 4 count 4", first, pcount);
    end
    mode = MODE_HALT;
    pcount = 0;
    for (int off = 1; off <= 20; off++) begin
      tick();
      if (PHI2_EN) pcount++;
      if (off == 1) begin
        n_cmp++;
        if (halted !== 1'b1) begin
          n_err++;
          $display("FAIL run_stop_halted: got %b, expected 1", halted);
        end
      end
    end
    n_cmp++;
    if (pcount !== 0) begin
      n_err++;
      $display("FAIL run_stop_pulses: got %0d, expected 0", pcount);
    end
  endtask

  task automatic test_breakpoint();
    int pcount = 0, first = -1;
    bit ab2 = 0, ab3 = 0, halt3 = 0, ab1 = 1, ab5 = 0, ab_any = 0;
    logic [NUM_BP-1:0] hit3 = '0, hit1 = '1, hit5 = '0;
    bp_addr = {16'hC000, 16'hC000}; bp_en = 2'b11; SYNC = 1; A = 16'hC000; div = 4'd1;
    tick();
    mode = MODE_RUN;
    for (int off = 1; off <= 8; off++) begin
      tick();
      if (PHI2_EN) pcount++;
      if (off == 2) ab2 = at_break;
      if (off == 3) begin ab3 = at_break; hit3 = bp_hit; halt3 = halted; end
    end
    n_cmp++;
    if (pcount !== 0 || {ab2, ab3, halt3} !== 3'b011) begin
      n_err++;
      $display("FAIL bp_break: got pulses %0d at_break %b%b halted %b, expected 0 01 1",
               pcount, ab2, ab3, halt3);
    end
    n_cmp++;
    if (hit3 !== 2'b11) begin
      n_err++;
      $display("FAIL bp_hit_mask: got %b, expected 11", hit3);
    end
    resume = 1; pcount = 0;
    for (int off = 1; off <= 8; off++) begin
      tick();
      if (off == 2) resume = 0;
      if (PHI2_EN) begin
        pcount++;
        if (first < 0) first = off;
      end
      if (off == 1) begin ab1 = at_break; hit1 = bp_hit; end
      if (off == 5) begin ab5 = at_break; hit5 = bp_hit; end
    end
    n_cmp++;
    if (ab1 !== 1'b0 || hit1 !== 2'b00) begin
      n_err++;
      $display("FAIL bp_resume_clear: got at_break %b bp_hit %b, expected 0 00", ab1, hit1);
    end
    n_cmp++;
    if (pcount !== 1 || first !== 3) begin
      n_err++;
      $display("FAIL bp_skip_once: got %0d pulses first %0d, expected 1 at 3", pcount, first);
    end
    n_cmp++;
    if (ab5 !== 1'b1 || hit5 !== 2'b11) begin
      n_err++;
      $display("FAIL bp_rebreak: got at_break %b bp_hit %b, expected 1 11", ab5, hit5);
    end
    A = 16'h1234; resume = 1; pcount = 0;
    for (int off = 1; off <= 20; off++) begin
      tick();
      if (off == 2) resume = 0;
      if (PHI2_EN) pcount++;
      if (at_break) ab_any = 1;
    end
    n_cmp++;
    if (pcount !== 9 || ab_any !== 1'b0) begin
      n_err++;
      $display("FAIL bp_run_after: got %0d pulses at_break %b, expected 9 0", pcount, ab_any);
    end
    mode = MODE_HALT; SYNC = 0; bp_en = '0;
    tick();
  endtask

  task automatic test_abort();
    int pcount = 0;
    bit aborted = 0;
    div = '0; burst_len = 8'd10; mode = MODE_BURST;
    repeat (2) tick();
    step_req = 1;
    for (int off = 1; off <= 40; off++) begin
      tick();
      if (off == 2) step_req = 0;
      if (PHI2_EN) pcount++;
      if (pcount == 4 && !aborted) begin
        mode = MODE_HALT;
        aborted = 1;
      end
    end
    n_cmp++;
    if (pcount !== 4 || halted !== 1'b1) begin
      n_err++;
      $display("FAIL burst_abort: got %0d pulses halted %b, expected 4 1", pcount, halted);
    end
  endtask

  task automatic test_reset_in_break();
    bit seen = 0;
    bp_addr = {16'h0000, 16'hBEEF}; bp_en = 2'b01; A = 16'hBEEF; SYNC = 1; div = '0;
    mode = MODE_HALT;
    repeat (2) tick();
    mode = MODE_RUN;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (at_break) seen = 1;
    end
    n_cmp++;
    if (!seen || bp_hit !== 2'b01) begin
      n_err++;
      $display("FAIL rst_break_entry: got at_break %b bp_hit %b, expected 1 01", seen, bp_hit);
    end
    #3 RESET_n = 1'b0;
    #1;
    n_cmp++;
    if ({PHI2_EN, halted, at_break, bp_hit} !== 5'b01000) begin
      n_err++;
      $display("FAIL rst_async: got %b, expected 01000", {PHI2_EN, halted, at_break, bp_hit});
    end
    mode = MODE_HALT; SYNC = 0; bp_en = '0;
    tick();
    RESET_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [4:0] got, exp;
    apply_reset();
    bp_addr = {16'hC004, 16'hC000};
    bp_en   = 2'b11;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)  step_req = ~step_req;
      if ($urandom_range(0, 7) == 0)  resume = ~resume;
      if ($urandom_range(0, 29) == 0) div = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 19) == 0)
        burst_len = ($urandom_range(0, 49) == 0) ? 8'd0 : 8'($urandom_range(1, 7));
      if ($urandom_range(0, 99) == 0) bp_en = 2'($urandom_range(0, 3));
      SYNC = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       A = 16'hC000;
        1:       A = 16'hC004;
        default: A = 16'($urandom);
      endcase
      RESET_n = !(i >= 2000 && i < 2002);
      tick();
      got = {PHI2_EN, halted, at_break, bp_hit};
      exp = {m_en, m_halted, m_brk, m_hit};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL random[%0d]: got en/halt/brk/hit %b, expected %b", i, got, exp);
      end
    end
    RESET_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_step();
    test_burst();
    test_burst_zero();
    test_run_div();
    test_breakpoint();
    test_abort();
    test_reset_in_break();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
